// File: rtl/secded_enc_pipe_72_64_pkg.sv
// Types and helper functions for the pipelined SECDED(72,64) encoder.
package secded_enc_pipe_72_64_pkg;
`include "secded_72_64_defs.vh"

  localparam int DATA_W = `SECDED_DATA_W;
  localparam int CODE_W = `SECDED_CODE_W;
  localparam int NPAR   = `SECDED_NPAR;

  typedef logic [DATA_W-1:0] data_t;
  typedef logic [CODE_W-1:0] code_t;

  function automatic code_t scatter(data_t d);
    code_t c;
    c = '0;
    for (int i = 0; i < DATA_W; i++) c[`SECDED_DATA_POS(i)] = d[i];
    return c;
  endfunction

  // Data positions covered by Hamming parity k.
  function automatic code_t cover_mask(int k);
    code_t m;
    m = '0;
    for (int p = 3; p < CODE_W; p++)
      if (((p >> k) & 1) == 1 && !(`SECDED_IS_PAR(p))) m[p] = 1'b1;
    return m;
  endfunction
endpackage

// File: rtl/secded_enc_pipe_72_64_if.sv
// Stream, injection and status signals of the SECDED encoder pipe.
interface secded_enc_pipe_72_64_if;
  import secded_enc_pipe_72_64_pkg::*;

  logic    in_valid;
  logic    in_ready;
  data_t   data_in;
  logic    out_valid;
  logic    out_ready;
  code_t   code_out;
  logic    inj_arm;
  code_t   inj_mask;
  logic    inj_pending;
  logic [15:0] word_cnt;

  modport slave (
    input  in_valid, data_in, out_ready, inj_arm, inj_mask,
    output in_ready, out_valid, code_out, inj_pending, word_cnt
  );
  modport master (
    output in_valid, data_in, out_ready, inj_arm, inj_mask,
    input  in_ready, out_valid, code_out, inj_pending, word_cnt
  );
endinterface

// File: rtl/secded_72_64_defs.vh
// Shared SECDED(72,64) constants: widths, parity positions and data-to-position map.
// Macro-only with a guard so the encoder package and the decoder can both include it.
`ifndef SECDED_72_64_DEFS_VH
`define SECDED_72_64_DEFS_VH

`define SECDED_DATA_W 64
`define SECDED_CODE_W 72
`define SECDED_NPAR   7

// Position 0 holds overall parity; 2^k hold the Hamming parities.
`define SECDED_IS_PAR(p) ((p)==0 || (p)==1 || (p)==2 || (p)==4 || (p)==8 || (p)==16 || (p)==32 || (p)==64)

// data[i] lands on the i-th position that is not a power of two.
`define SECDED_DATA_POS(i) ((i)==0 ? 3 : (i)<=3 ? (i)+4 : (i)<=10 ? (i)+5 : (i)<=25 ? (i)+6 : (i)<=56 ? (i)+7 : (i)+8)

`endif

// File: rtl/secded_enc_pipe_72_64_parity_gen.sv
// Combinational Hamming stage: scatters data and fills the seven 2^k parities; code[0] left 0.
module secded_parity_gen_72_64
  import secded_enc_pipe_72_64_pkg::*;
(
  input  data_t data,
  output code_t code
);
  code_t scat;

  assign scat = scatter(data);

  always_comb begin
    code = scat;
    for (int k = 0; k < NPAR; k++) code[1 << k] = ^(scat & cover_mask(k));
  end
endmodule

// File: rtl/secded_enc_pipe_72_64.sv
// Two-stage SECDED(72,64) encoder with valid/ready flow control and one-shot error injection.
module secded_enc_pipe_72_64
  import secded_enc_pipe_72_64_pkg::*;
(
  input logic clk,
  input logic rst_n,
  secded_enc_pipe_72_64_if.slave bus
);
  logic        s1_valid, s2_valid;
  logic        s1_load, s2_load, word_load;
  code_t       enc, s1_code, s2_code, inj_mask_q;
  logic        inj_pend;
  logic [15:0] cnt;

  secded_parity_gen_72_64 u_gen (.data(bus.data_in), .code(enc));

  // Each stage advances when it is empty or its successor advances.
  assign s2_load   = ~s2_valid | bus.out_ready;
  assign s1_load   = ~s1_valid | s2_load;
  assign word_load = s2_load & s1_valid;

  assign bus.in_ready    = s1_load;
  assign bus.out_valid   = s2_valid;
  assign bus.code_out    = s2_code;
  assign bus.inj_pending = inj_pend;
  assign bus.word_cnt    = cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_code  <= '0;
    end else if (s1_load) begin
      s1_valid <= bus.in_valid;
      if (bus.in_valid) s1_code <= enc;
    end
  end

  // s1_code[0] is 0, so folding it into the overall parity is harmless.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid <= 1'b0;
      s2_code  <= '0;
    end else if (s2_load) begin
      s2_valid <= s1_valid;
      if (s1_valid)
        s2_code <= {s1_code[CODE_W-1:1], ^s1_code} ^ (inj_pend ? inj_mask_q : '0);
    end
  end

  // A fresh arm wins over consumption, so a mask armed during a load hits the next word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inj_pend   <= 1'b0;
      inj_mask_q <= '0;
    end else if (bus.inj_arm) begin
      inj_pend   <= 1'b1;
      inj_mask_q <= bus.inj_mask;
    end else if (word_load) begin
      inj_pend   <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                         cnt <= '0;
    else if (s2_valid & bus.out_ready)  cnt <= cnt + 16'd1;
  end
endmodule

// File: tb/tb_secded_enc_pipe_72_64.sv
// Bench for secded_enc_pipe_72_64: directed and random words against a syndrome-based model.
module tb_secded_enc_pipe_72_64;
  logic clk;
  logic rst_n;
  secded_enc_pipe_72_64_if bus ();

  secded_enc_pipe_72_64 dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  logic [63:0] acc_q[$];
  logic [71:0] out_q[$];

  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.in_valid && bus.in_ready)   acc_q.push_back(bus.data_in);
      if (bus.out_valid && bus.out_ready) out_q.push_back(bus.code_out);
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_out(input int n);
    for (int c = 0; c < 300 && out_q.size() < n; c++) step();
    chk("out_count", out_q.size(), n);
  endtask

  // Parities chosen so that the XOR of all set-bit positions is zero.
  function automatic logic [71:0] ref_enc(input logic [63:0] d);
    logic [71:0] c;
    logic [6:0]  syn;
    int j;
    c = '0; syn = '0; j = 0;
    for (int p = 1; p < 72; p++)
      if ((p & (p - 1)) != 0) begin
        c[p] = d[j];
        if (d[j]) syn = syn ^ p[6:0];
        j++;
      end
    for (int k = 0; k < 7; k++) c[1 << k] = syn[k];
    c[0] = ^c[71:1];
    return c;
  endfunction

  function automatic void ref_dec(input logic [71:0] c, output logic [6:0] syn,
                                  output logic ovr, output logic [63:0] d);
    logic [71:0] x;
    int j;
    syn = '0;
    for (int p = 1; p < 72; p++) if (c[p]) syn = syn ^ p[6:0];
    ovr = ^c;
    x = c;
    if (ovr && syn < 7'd72) x[syn] = ~x[syn];
    j = 0;
    d = '0;
    for (int p = 1; p < 72; p++)
      if ((p & (p - 1)) != 0) begin
        d[j] = x[p];
        j++;
      end
  endfunction

  logic [6:0]  syn;
  logic        ovr;
  logic [63:0] dd, wa, wb;
  logic [71:0] snap;
  int exp_cnt;

  initial begin
    rst_n = 1'b0;
    bus.in_valid = 0; bus.data_in = '0; bus.out_ready = 0;
    bus.inj_arm = 0; bus.inj_mask = '0;
    exp_cnt = 0;
    repeat (2) @(negedge clk);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_in_ready", bus.in_ready, 1);
    chk("rst_inj_pending", bus.inj_pending, 0);
    chk("rst_word_cnt", bus.word_cnt, 0);
    chk("rst_code_out", bus.code_out, 0);

    // first accept right after release, then latency of two cycles
    step();
    rst_n = 1'b1; bus.in_valid = 1; bus.data_in = '0; bus.out_ready = 1;
    @(negedge clk); chk("first_accept_ready", bus.in_ready, 1);
    step(); bus.in_valid = 0;
    @(negedge clk); chk("lat_s1_only", bus.out_valid, 0);
    step();
    @(negedge clk); chk("lat_out_valid", bus.out_valid, 1);
    chk("zero_code", bus.code_out, 72'h0);
    step();
    @(negedge clk); chk("cnt_after_first", bus.word_cnt, 1);
    exp_cnt += out_q.size(); acc_q.delete(); out_q.delete();

    step(); bus.in_valid = 1; bus.data_in = 64'h1;
    step(); bus.in_valid = 0;
    wait_out(1);
    if (out_q.size() > 0) chk("one_code", out_q[0], 72'h00_0000_0000_0000_000F);
    exp_cnt += out_q.size(); acc_q.delete(); out_q.delete();

    // random stream with random backpressure
    for (int g = 0; g < 60000 && acc_q.size() < 10000; g++) begin
      bus.in_valid  = ($urandom_range(3) != 0);
      bus.data_in   = {$urandom, $urandom};
      bus.out_ready = ($urandom_range(3) != 0);
      step();
    end
    bus.in_valid = 0; bus.out_ready = 1;
    chk("rand_accepted", acc_q.size(), 10000);
    wait_out(acc_q.size());
    for (int i = 0; i < out_q.size() && i < acc_q.size(); i++) begin
      ref_dec(out_q[i], syn, ovr, dd);
      chk("rand_code", out_q[i], ref_enc(acc_q[i]));
      chk("rand_no_error", {syn, ovr}, 0);
      chk("rand_data", dd, acc_q[i]);
    end
    exp_cnt += out_q.size(); acc_q.delete(); out_q.delete();
    @(negedge clk); chk("rand_word_cnt", bus.word_cnt, 16'(exp_cnt));

    // single-bit injection then a clean word
    wa = {$urandom, $urandom}; wb = {$urandom, $urandom};
    step(); bus.inj_arm = 1; bus.inj_mask = 72'h20;
    step(); bus.inj_arm = 0; bus.inj_mask = '0;
    @(negedge clk); chk("inj_pending_set", bus.inj_pending, 1);
    step(); bus.in_valid = 1; bus.data_in = wa;
    step(); bus.data_in = wb;
    step(); bus.in_valid = 0;
    wait_out(2);
    if (out_q.size() >= 2) begin
      ref_dec(out_q[0], syn, ovr, dd);
      chk("inj_single", ovr, 1);
      chk("inj_position", syn, 7'd5);
      chk("inj_corrected", dd, wa);
      chk("inj_next_clean", out_q[1], ref_enc(wb));
    end
    @(negedge clk); chk("inj_pending_clr", bus.inj_pending, 0);
    acc_q.delete(); out_q.delete();

    // double-bit injection
    wa = {$urandom, $urandom};
    step(); bus.inj_arm = 1; bus.inj_mask = 72'h408;
    step(); bus.inj_arm = 0; bus.inj_mask = '0;
    bus.in_valid = 1; bus.data_in = wa;
    step(); bus.in_valid = 0;
    wait_out(1);
    if (out_q.size() >= 1) begin
      ref_dec(out_q[0], syn, ovr, dd);
      chk("dbl_overall_even", ovr, 0);
      chk("dbl_detect", (syn != 0), 1);
    end
    acc_q.delete(); out_q.delete();

    // zero mask flips nothing
    wa = {$urandom, $urandom};
    step(); bus.inj_arm = 1; bus.inj_mask = '0;
    step(); bus.inj_arm = 0;
    bus.in_valid = 1; bus.data_in = wa;
    step(); bus.in_valid = 0;
    wait_out(1);
    if (out_q.size() >= 1) chk("zero_mask_code", out_q[0], ref_enc(wa));
    @(negedge clk); chk("zero_mask_pend", bus.inj_pending, 0);
    acc_q.delete(); out_q.delete();

    // backpressure: sink stalls six cycles with the source always valid
    step(); bus.out_ready = 0; bus.in_valid = 1; bus.data_in = 64'hB0;
    snap = '0;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      bus.data_in = 64'hB0 + 64'(acc_q.size());
      @(negedge clk);
      if (c == 1) snap = bus.code_out;
      else if (c > 1) begin
        chk("stall_code_stable", bus.code_out, snap);
        chk("stall_out_valid", bus.out_valid, 1);
      end
    end
    chk("stall_accepted", acc_q.size(), 2);
    chk("stall_in_ready", bus.in_ready, 0);
    step(); bus.out_ready = 1; bus.data_in = 64'hB0 + 64'(acc_q.size());
    for (int g = 0; g < 100 && acc_q.size() < 6; g++) begin
      step();
      bus.data_in = 64'hB0 + 64'(acc_q.size());
    end
    bus.in_valid = 0;
    wait_out(6);
    for (int i = 0; i < out_q.size(); i++) begin
      ref_dec(out_q[i], syn, ovr, dd);
      chk("stall_order", dd, 64'hB0 + 64'(i));
    end
    acc_q.delete(); out_q.delete();

    // reset with two words in flight
    step(); bus.out_ready = 0; bus.in_valid = 1; bus.data_in = {$urandom, $urandom};
    step(); bus.data_in = {$urandom, $urandom};
    step(); bus.in_valid = 0;
    @(negedge clk); chk("pre_rst_out_valid", bus.out_valid, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", bus.out_valid, 0);
    chk("mid_rst_code_out", bus.code_out, 0);
    chk("mid_rst_in_ready", bus.in_ready, 1);
    step(); step();
    rst_n = 1'b1; bus.out_ready = 1;
    acc_q.delete();
    repeat (10) step();
    chk("rst_no_ghost", out_q.size(), 0);
    @(negedge clk); chk("rst_word_cnt_zero", bus.word_cnt, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/secded_enc_pipe_72_64.md
SECDED_ENC_PIPE_72_64 -- requirements
Module: secded_enc_pipe_72_64

Interface
REQ-001 SHALL have ports: clk  input  1  sole clock, all state on rising edge.
REQ-002 SHALL have ports: rst_n  input  1  reset, asynchronous, active-low.
REQ-003 SHALL have ports: in_valid  input  1  data_in valid.
REQ-004 SHALL have ports: in_ready  output  1  block accepts data_in this cycle.
REQ-005 SHALL have ports: data_in  input  64  payload word.
REQ-006 SHALL have ports: out_valid  output  1  code_out valid.
REQ-007 SHALL have ports: out_ready  input  1  sink accepts code_out.
REQ-008 SHALL have ports: code_out  output  72  encoded codeword, bit p = Hamming position p.
REQ-009 SHALL have ports: inj_arm  input  1  one-cycle pulse, latch inj_mask for the next emitted word.
REQ-010 SHALL have ports: inj_mask  input  72  bits to flip in one emitted codeword.
REQ-011 SHALL have ports: inj_pending  output  1  armed mask not yet consumed.
REQ-012 SHALL have ports: word_cnt  output  16  count of codewords transferred on output.

Function
REQ-013 SHALL place data at positions that are not powers of two: data[0]->3, data[3:1]->7:5, data[10:4]->15:9, data[25:11]->31:17, data[56:26]->63:33, data[63:57]->71:65.
REQ-014 SHALL set code[2^k], k=0..6, to the XOR of all data positions p in 3..71 with bit k of p set; P64 covers 65..71 only.
REQ-015 SHALL set code[0] = XOR of code[71:1], giving even overall parity.
REQ-016 Decoding an uninjected word SHALL yield zero syndrome, even overall parity, and data equal to data_in.
REQ-017 SHALL be two stages: S1 registers data and the seven Hamming parities; S2 registers the overall parity and the injection XOR; latency 2 cycles from accept to out_valid with no backpressure.
REQ-018 A transfer SHALL occur only when valid and ready are both high in the same cycle.
REQ-019 Stage advance: S2 loads when ~s2_valid | out_ready; S1 loads when ~s1_valid | S2 loads; in_ready = S1 loads (bubbles collapse).
REQ-020 code_out and out_valid SHALL be held stable while out_valid & ~out_ready.
REQ-021 Throughput SHALL be one word per cycle while out_ready is held high.
REQ-022 inj_arm SHALL latch inj_mask and set inj_pending; code_out = encoded ^ mask for the next word loaded into S2.
REQ-023 inj_pending SHALL clear on the cycle that word loads into S2.
REQ-024 If inj_arm coincides with an S2 load while pending, the new mask SHALL apply to the following word.
REQ-025 inj_mask = 0 SHALL be legal and SHALL flip nothing.
REQ-026 word_cnt SHALL increment on each output transfer and wrap from 16'hFFFF to 0.

Reset
REQ-027 While rst_n is low: s1_valid, s2_valid, out_valid, inj_pending, the injection mask, code_out and word_cnt SHALL be 0; in_ready SHALL be 1.
REQ-028 Assertion mid-stream SHALL discard all in-flight words with no partial output.
REQ-029 The first accept SHALL be possible on the first rising edge after deassertion.

Structure
REQ-030 Parity position constants (0,1,2,4,8,16,32,64), the widths 64/72, and the data-to-position map SHALL live in shared header secded_72_64_defs.vh, reused by the existing decoder.
REQ-031 Hamming parity generation SHALL be a combinational sub-module secded_parity_gen_72_64 (64 in, 72 out with code[0]=0); overall parity SHALL be computed in S2.

Verification
REQ-032 Bench SHALL cover: data_in 64'h0, no injection -> code_out 72'h0 two cycles later, word_cnt=1.
REQ-033 Bench SHALL cover: data_in 64'h1 -> code_out 72'h00_0000_0000_0000_000F.
REQ-034 Bench SHALL cover: 10,000 random words fed through the existing decoder -> no_error=1 and data_out==data_in every word.
REQ-035 Bench SHALL cover: inj_mask bit 5 armed -> decoder single_error=1, error_position=7'd5, data corrected; next word clean; and mask bits {3,10} -> double_error=1.
REQ-036 Bench SHALL cover: out_ready low 6 cycles with in_valid high -> exactly 2 words accepted, in_ready=0, code_out stable; on release, words emerge in order with none lost or duplicated.
REQ-037 Bench SHALL cover: rst_n pulsed low with 2 words in flight -> out_valid=0 immediately, and those words never appear.
